// File: rtl/sort_ctrl_pkg.sv
// Shared defaults and FSM state encoding for the batch bubble-sort controller.
package sort_ctrl_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/sort_ctrl_cmp_core.sv
// Purely combinational signed magnitude comparator shared by the sort datapath.
module cmp_core #(
  parameter int WIDTH = 4
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    gt,
  output logic                    eq,
  output logic                    lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/sort_ctrl.sv
// Batch controller: loads DEPTH signed words, bubble-sorts them in place with one
// shared comparator (early exit on a swap-free pass), then streams them out ascending.
module sort_ctrl
  import sort_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_data,
  input  logic                    out_ready,
  output logic                    busy,
  output logic [3:0]              pass_cnt
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST     = IW'(DEPTH - 1);
  localparam logic [IW-1:0] CMP_LAST = IW'(DEPTH - 2);
  localparam logic [3:0]    PASS_MAX = 4'(DEPTH - 2);

  state_t state, state_nx;

  logic signed [WIDTH-1:0] entry [DEPTH];
  logic [IW-1:0]           wr_idx, rd_idx, idx, idx_n;
  logic                    swapped;
  logic signed [WIDTH-1:0] cmp_a, cmp_b;
  logic                    gt, eq, lt, swap, pass_end, stop;

  assign idx_n = idx + 1'b1;
  assign cmp_a = entry[idx];
  assign cmp_b = entry[idx_n];

  cmp_core #(.WIDTH(WIDTH)) u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .gt (gt),
    .eq (eq),
    .lt (lt)
  );

  // Equal operands never swap, which keeps the sort stable.
  assign swap     = gt & ~(eq | lt);
  assign pass_end = (idx == CMP_LAST);
  assign stop     = !(swapped || swap) || (pass_cnt == PASS_MAX);

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && wr_idx == LAST) state_nx = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (pass_end && stop) state_nx = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        out_data  = entry[rd_idx];
        if (out_ready && rd_idx == LAST) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry    <= '{default: '0};
      wr_idx   <= '0;
      rd_idx   <= '0;
      idx      <= '0;
      pass_cnt <= '0;
      swapped  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            entry[wr_idx] <= in_data;
            wr_idx        <= (wr_idx == LAST) ? '0 : wr_idx + 1'b1;
          end
        end
        SORT: begin
          if (swap) begin
            entry[idx]   <= cmp_b;
            entry[idx_n] <= cmp_a;
            swapped      <= 1'b1;
          end
          // Pass boundary: per-pass swap flag restarts, overriding the set above.
          if (pass_end) begin
            pass_cnt <= pass_cnt + 4'd1;
            idx      <= '0;
            swapped  <= 1'b0;
          end else begin
            idx <= idx_n;
          end
        end
        OUT: begin
          if (out_ready) begin
            if (rd_idx == LAST) begin
              rd_idx   <= '0;
              wr_idx   <= '0;
              pass_cnt <= '0;
            end else begin
              rd_idx <= rd_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_ctrl.sv
// Directed bench for sort_ctrl (WIDTH=4, DEPTH=4) with hand-computed expectations.
module tb_sort_ctrl;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic signed [3:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic signed [3:0] out_data;
  logic              out_ready = 1'b0;
  logic              busy;
  logic [3:0]        pass_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sort_ctrl #(.WIDTH(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .pass_cnt  (pass_cnt)
  );

  // Stimulus drivers; all edges driven and sampled on negedge.
  task automatic load_batch(input logic signed [3:0] v [4], input logic hold_valid);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = v[k];
      @(negedge clk);
    end
    if (hold_valid) in_data = -4'sd8;
    else            in_valid = 1'b0;
  endtask

  task automatic run_sort(output int cyc, output int rdy_hi);
    cyc = 0;
    rdy_hi = 0;
    while (busy && cyc < 40) begin
      if (in_ready) rdy_hi++;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic read_batch(output logic signed [3:0] got [4], output int vld_lo);
    vld_lo = 0;
    for (int k = 0; k < 4; k++) begin
      out_ready = 1'b1;
      got[k] = out_data;
      if (!out_valid) vld_lo++;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 4'sd0) begin errors++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
    checks++; if (pass_cnt !== 4'd0) begin errors++; $display("FAIL reset_pass_cnt got=%0d exp=0", pass_cnt); end
  endtask

  task automatic test_mixed_signs;
    logic signed [3:0] v [4];
    logic signed [3:0] e [4];
    logic signed [3:0] got [4];
    int cyc, rdy, vlo;
    v = '{4'sd3, -4'sd2, 4'sd7, -4'sd8};
    e = '{-4'sd8, -4'sd2, 4'sd3, 4'sd7};
    load_batch(v, 1'b0);
    run_sort(cyc, rdy);
    checks++; if (cyc != 9) begin errors++; $display("FAIL mixed_sort_cycles got=%0d exp=9", cyc); end
    checks++; if (pass_cnt !== 4'd3) begin errors++; $display("FAIL mixed_pass_cnt got=%0d exp=3", pass_cnt); end
    read_batch(got, vlo);
    checks++; if (vlo != 0) begin errors++; $display("FAIL mixed_out_valid low_count got=%0d exp=0", vlo); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== e[k]) begin errors++; $display("FAIL mixed_out[%0d] got=%0d exp=%0d", k, got[k], e[k]); end
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mixed_back_to_load got=%b exp=1", in_ready); end
    checks++; if (pass_cnt !== 4'd0) begin errors++; $display("FAIL mixed_pass_cleared got=%0d exp=0", pass_cnt); end
  endtask

  task automatic test_presorted;
    logic signed [3:0] v [4];
    logic signed [3:0] got [4];
    int cyc, rdy, vlo;
    v = '{-4'sd1, 4'sd0, 4'sd1, 4'sd2};
    load_batch(v, 1'b0);
    run_sort(cyc, rdy);
    checks++; if (cyc != 3) begin errors++; $display("FAIL presorted_sort_cycles got=%0d exp=3", cyc); end
    checks++; if (pass_cnt !== 4'd1) begin errors++; $display("FAIL presorted_pass_cnt got=%0d exp=1", pass_cnt); end
    read_batch(got, vlo);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== v[k]) begin errors++; $display("FAIL presorted_out[%0d] got=%0d exp=%0d", k, got[k], v[k]); end
    end
  endtask

  task automatic test_equal;
    logic signed [3:0] v [4];
    logic signed [3:0] e [4];
    logic signed [3:0] got [4];
    int cyc, rdy, vlo;
    v = '{4'sd5, 4'sd5, -4'sd1, 4'sd5};
    e = '{-4'sd1, 4'sd5, 4'sd5, 4'sd5};
    load_batch(v, 1'b0);
    run_sort(cyc, rdy);
    checks++; if (cyc != 9) begin errors++; $display("FAIL equal_sort_cycles got=%0d exp=9", cyc); end
    checks++; if (pass_cnt !== 4'd3) begin errors++; $display("FAIL equal_pass_cnt got=%0d exp=3", pass_cnt); end
    read_batch(got, vlo);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== e[k]) begin errors++; $display("FAIL equal_out[%0d] got=%0d exp=%0d", k, got[k], e[k]); end
    end
  endtask

  task automatic test_backpressure;
    logic signed [3:0] v [4];
    logic signed [3:0] e [4];
    logic signed [3:0] got [4];
    int cyc, rdy, vlo;
    v = '{4'sd3, -4'sd2, 4'sd7, -4'sd8};
    e = '{-4'sd8, -4'sd2, 4'sd3, 4'sd7};
    load_batch(v, 1'b0);
    run_sort(cyc, rdy);
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid[%0d] got=%b exp=1", k, out_valid); end
      checks++; if (out_data !== -4'sd8) begin errors++; $display("FAIL stall_out_data[%0d] got=%0d exp=-8", k, out_data); end
      @(negedge clk);
    end
    read_batch(got, vlo);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== e[k]) begin errors++; $display("FAIL stall_out[%0d] got=%0d exp=%0d", k, got[k], e[k]); end
    end
  endtask

  task automatic test_reset_mid_sort;
    logic signed [3:0] v [4];
    logic signed [3:0] w [4];
    logic signed [3:0] got [4];
    int cyc, rdy, vlo;
    v = '{4'sd3, -4'sd2, 4'sd7, -4'sd8};
    w = '{4'sd7, 4'sd6, 4'sd5, 4'sd4};
    load_batch(v, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1 || pass_cnt !== 4'd1) begin errors++; $display("FAIL midsort_pass2 busy=%b pass=%0d exp busy=1 pass=1", busy, pass_cnt); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midsort_in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midsort_busy got=%b exp=0", busy); end
    checks++; if (pass_cnt !== 4'd0) begin errors++; $display("FAIL midsort_pass_cnt got=%0d exp=0", pass_cnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midsort_out_valid got=%b exp=0", out_valid); end
    load_batch(w, 1'b0);
    run_sort(cyc, rdy);
    checks++; if (cyc != 9) begin errors++; $display("FAIL fresh_sort_cycles got=%0d exp=9", cyc); end
    read_batch(got, vlo);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== w[3-k]) begin errors++; $display("FAIL fresh_out[%0d] got=%0d exp=%0d", k, got[k], w[3-k]); end
    end
  endtask

  task automatic test_ignore_inputs;
    logic signed [3:0] v [4];
    logic signed [3:0] got [4];
    int cyc, rdy, vlo;
    v = '{-4'sd1, 4'sd0, 4'sd1, 4'sd2};
    load_batch(v, 1'b1);
    run_sort(cyc, rdy);
    checks++; if (rdy != 0) begin errors++; $display("FAIL ignore_sort_in_ready high_count got=%0d exp=0", rdy); end
    checks++; if (cyc != 3) begin errors++; $display("FAIL ignore_sort_cycles got=%0d exp=3", cyc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ignore_out_in_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    read_batch(got, vlo);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== v[k]) begin errors++; $display("FAIL ignore_out[%0d] got=%0d exp=%0d", k, got[k], v[k]); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mixed_signs();
    test_presorted();
    test_equal();
    test_backpressure();
    test_reset_mid_sort();
    test_ignore_inputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sort_ctrl.md
SORT_CTRL -- requirements
Module: sort_ctrl

Interface
REQ-001 The module SHALL have parameter WIDTH, default `WIDTH from define.h (4), as the signed data word width.
REQ-002 The module SHALL have parameter DEPTH, default 4, as the number of entries per sort batch (2..16).
REQ-003 The module SHALL have port clk, input, 1 bit, as the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit, as the reset: synchronous, active-high.
REQ-005 The module SHALL have port in_valid, input, 1 bit, as the load-word-present flag.
REQ-006 The module SHALL have port in_data, input, WIDTH bits, signed, as the load word.
REQ-007 The module SHALL have port in_ready, output, 1 bit, high only in LOAD.
REQ-008 The module SHALL have port out_valid, output, 1 bit, high when out_data is valid.
REQ-009 The module SHALL have port out_data, output, WIDTH bits, signed, as the sorted word.
REQ-010 The module SHALL have port out_ready, input, 1 bit, as the consumer accept flag.
REQ-011 The module SHALL have port busy, output, 1 bit, high in SORT.
REQ-012 The module SHALL have port pass_cnt, output, 4 bits, as the number of completed sort passes for the current batch.

Function
REQ-013 The controller SHALL be an FSM with states LOAD, SORT and OUT.
REQ-014 In LOAD, each cycle with in_valid && in_ready SHALL write in_data to entry[wr_idx] and increment wr_idx.
REQ-015 When the DEPTH-th word is accepted, the FSM SHALL enter SORT on the next edge and in_ready SHALL drop in the same cycle.
REQ-016 In SORT, each cycle SHALL compare entry[i] with entry[i+1] using one shared signed comparator (Gt/Eq/Lt).
REQ-017 When Gt is asserted in SORT, the two entries SHALL be swapped at the clock edge; on Eq or Lt, no swap SHALL occur, so equal values keep their order.
REQ-018 In SORT, i SHALL advance 0..DEPTH-2; each pass SHALL take DEPTH-1 cycles.
REQ-019 At the end of each pass, pass_cnt SHALL increment.
REQ-020 If no swap occurred in a pass, or pass_cnt reaches DEPTH-1, the FSM SHALL enter OUT; otherwise it SHALL start a new pass with i=0.
REQ-021 Comparison SHALL be two's-complement signed: -8 < 7 for WIDTH=4.
REQ-022 In OUT, out_data SHALL present entry[rd_idx] in ascending order with out_valid high.
REQ-023 In OUT, rd_idx SHALL advance only on out_valid && out_ready; out_data SHALL hold stable while out_ready is low.
REQ-024 After the last word is accepted in OUT, the FSM SHALL return to LOAD and clear wr_idx, rd_idx and pass_cnt.
REQ-025 in_valid outside LOAD SHALL be ignored; out_ready outside OUT SHALL be ignored.
REQ-026 Simultaneous in_valid and out_ready cannot both be effective because the states are exclusive.
REQ-027 Worst-case batch latency SHALL be DEPTH load cycles + (DEPTH-1)^2 sort cycles + DEPTH output handshakes.

Reset
REQ-028 While rst is high at a clock edge, the FSM SHALL go to LOAD regardless of state, including mid-SORT and mid-OUT.
REQ-029 Reset SHALL clear all entries, wr_idx, rd_idx and pass_cnt to 0.
REQ-030 After reset, out_valid SHALL be 0, out_data 0, busy 0, pass_cnt 0 and in_ready 1; a partial batch SHALL be discarded.

Structure
REQ-031 define.h SHALL hold WIDTH, DEPTH and the state encodings (LOAD=2'd0, SORT=2'd1, OUT=2'd2).
REQ-032 The comparator SHALL be a separate sub-module, cmp_core (signed A, B -> Gt, Eq, Lt, purely combinational), instantiated exactly once.
REQ-033 The entry storage and FSM SHALL reside in sort_ctrl.

Verification (WIDTH=4, DEPTH=4)
REQ-034 Load 3,-2,7,-8 with out_ready=1 -> out 8'... sequence -8,-2,3,7; pass_cnt=3.
REQ-035 Load -1,0,1,2 (presorted) -> SORT lasts exactly 3 cycles, pass_cnt=1, out -1,0,1,2.
REQ-036 Load 5,5,-1,5 -> out -1,5,5,5; no swap recorded between equal entries.
REQ-037 OUT with out_ready held low for 3 cycles -> out_valid=1 and out_data=-8 held constant, rd_idx unchanged.
REQ-038 Assert rst for 1 cycle during the second SORT pass -> next cycle in_ready=1, busy=0, pass_cnt=0, out_valid=0; a fresh batch 7,6,5,4 -> out 4,5,6,7.
REQ-039 Drive in_valid=1 during SORT and OUT -> no entry changes and in_ready stays 0.
